ped_crossing_ctrl: RTL and testbench

Pedestrian crossing controller sitting directly downstream of `traffic_light`. It consumes that block's `red`/`yellow`/`green` outputs together with a pedestrian push-button and drives the WALK / DON'T WALK lamps and a clearance countdown. WALK is granted only while the vehicle signal is red, and only after a latched request. The block also checks that the vehicle lamps are one-hot and latches a sticky fault otherwise.

---
 rtl/ped_crossing_ctrl.sv | 136 +++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller placed downstream of traffic_light.
// Grants WALK only on a vehicle red rise with a latched (or simultaneous) request,
// then runs a clearance countdown. Watches the vehicle lamps for a non-one-hot
// code and latches a sticky fault.
// Build option: define PED_FLASH_EN to flash dont_walk during clearance.
module ped_crossing_ctrl #(
    parameter int unsigned WALK_CYCLES  = 6,
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             ped_button,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWalk  = 2'd1;
    localparam logic [1:0] StClear = 2'd2;
    localparam logic [1:0] StFault = 2'd3;

    localparam logic [CNT_W-1:0] WalkLoad  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ClearLoad = CNT_W'(CLEAR_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             red_q;
    logic             bad_q;
    logic             bad;
    logic             red_rise;
    logic             req_d;
    logic             walk_d;
    logic             dont_walk_d;
    logic [CNT_W-1:0] countdown_d;
    logic             fault_d;

    // Next-state, request latch and registered-output precomputation
    always_comb begin
        bad      = !(({red, yellow, green} == 3'b100) ||
                     ({red, yellow, green} == 3'b010) ||
                     ({red, yellow, green} == 3'b001));
        red_rise = red & ~red_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_pending;

        // Two consecutive bad samples win over every other transition
        if (state_q != StFault && bad && bad_q) begin
            state_d = StFault;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (red_rise && (req_pending || ped_button)) begin
                        state_d = StWalk;
                        cnt_d   = WalkLoad;
                        req_d   = 1'b0;
                    end else if (ped_button) begin
                        req_d = 1'b1;
                    end
                end
                StWalk: begin
                    if (!red) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = StClear;
                        cnt_d   = ClearLoad;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StClear: begin
                    if (ped_button) req_d = 1'b1;
                    if (!red || cnt_q == '0) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    // Fault is left only through reset; request is frozen
                    state_d = StFault;
                end
            endcase
        end

        walk_d      = (state_d == StWalk);
        fault_d     = (state_d == StFault);
        countdown_d = (state_d == StClear) ? cnt_d + 1'b1 : '0;
`ifdef PED_FLASH_EN
        // Steady on the first clearance cycle, then alternate
        if (state_d == StClear && state_q == StClear) begin
            dont_walk_d = ~dont_walk;
        end else begin
            dont_walk_d = (state_d != StWalk);
        end
`else
        dont_walk_d = (state_d != StWalk);
`endif
    end

    // State, counter, lamp history and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            red_q       <= 1'b1;
            bad_q       <= 1'b0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            req_pending <= 1'b0;
            countdown   <= '0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            red_q       <= red;
            bad_q       <= bad;
            walk        <= walk_d;
            dont_walk   <= dont_walk_d;
            req_pending <= req_d;
            countdown   <= countdown_d;
            fault       <= fault_d;
        end
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Self-checking bench for ped_crossing_ctrl: an elapsed-time model of the
// crossing is compared with the DUT every cycle, plus literal spot checks.
module tb_ped_crossing_ctrl;

    localparam int W = 6;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       red, yellow, green, ped_button;
    logic       walk, dont_walk, req_pending, fault;
    logic [3:0] countdown;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: service in progress and cycles elapsed since it started
    bit m_busy, m_fault, m_req, m_red_prev, m_bad_prev;
    int m_t;

    ped_crossing_ctrl #(
        .WALK_CYCLES (W),
        .CLEAR_CYCLES(C),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .ped_button (ped_button),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .req_pending(req_pending),
        .countdown  (countdown),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_lamps(input logic r, input logic y, input logic g);
        red    = r;
        yellow = y;
        green  = g;
    endtask

    // Reference model, advanced on each sampling edge
    always @(posedge clk) begin
        int  lit;
        bit  bad, rise;
        lit  = int'(red) + int'(yellow) + int'(green);
        bad  = (lit != 1);
        rise = red && !m_red_prev;
        if (reset) begin
            m_busy = 0; m_fault = 0; m_req = 0; m_t = 0;
            m_red_prev = 1; m_bad_prev = 0;
        end else begin
            if (m_fault) begin
                // frozen
            end else if (bad && m_bad_prev) begin
                m_fault = 1;
                m_busy  = 0;
            end else if (!m_busy) begin
                if (rise && (m_req || ped_button)) begin
                    m_busy = 1; m_t = 0; m_req = 0;
                end else if (ped_button) begin
                    m_req = 1;
                end
            end else begin
                if (m_t >= W && ped_button) m_req = 1;
                if (!red) begin
                    m_busy = 0;
                end else begin
                    m_t++;
                    if (m_t == W + C) m_busy = 0;
                end
            end
            m_red_prev = red;
            m_bad_prev = bad;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int e_walk, e_dw, e_cd;
        if (chk_en) begin
            e_walk = (!m_fault && m_busy && m_t < W) ? 1 : 0;
            e_cd   = (!m_fault && m_busy && m_t >= W) ? (W + C - m_t) : 0;
            e_dw   = e_walk ? 0 : 1;
`ifdef PED_FLASH_EN
            if (!m_fault && m_busy && m_t >= W) e_dw = (((m_t - W) % 2) == 0) ? 1 : 0;
`endif
            check("walk", int'(walk), e_walk);
            check("dont_walk", int'(dont_walk), e_dw);
            check("countdown", int'(countdown), e_cd);
            check("req_pending", int'(req_pending), int'(m_req));
            check("fault", int'(fault), int'(m_fault));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ped_button = 1'b0;
        set_lamps(1, 0, 0);
        tick(1);
        chk_en = 1'b1;
        tick(2);
        reset = 1'b0;

        // Red held through reset, no press: nothing happens
        tick(20);
        check("idle_walk", int'(walk), 0);
        check("idle_dont_walk", int'(dont_walk), 1);
        check("idle_req", int'(req_pending), 0);

        // Press on green, then green->yellow->red full service
        set_lamps(0, 0, 1);
        tick(2);
        ped_button = 1'b1;
        tick(1);
        ped_button = 1'b0;
        check("req_latched", int'(req_pending), 1);
        tick(2);
        set_lamps(0, 1, 0);
        tick(2);
        check("req_held", int'(req_pending), 1);
        set_lamps(1, 0, 0);
        tick(1);
        check("walk_start", int'(walk), 1);
        check("req_cleared", int'(req_pending), 0);
        tick(5);
        check("walk_last", int'(walk), 1);
        tick(1);
        check("clear_walk", int'(walk), 0);
        check("clear_cd4", int'(countdown), 4);
        tick(3);
        check("clear_cd1", int'(countdown), 1);
        tick(1);
        check("done_cd0", int'(countdown), 0);
        check("done_dw", int'(dont_walk), 1);

        // Press coinciding with the red rise, then red drops at WALK cycle 3
        set_lamps(0, 0, 1);
        tick(3);
        set_lamps(1, 0, 0);
        ped_button = 1'b1;
        tick(1);
        ped_button = 1'b0;
        check("same_edge_walk", int'(walk), 1);
        check("same_edge_req", int'(req_pending), 0);
        tick(2);
        set_lamps(0, 0, 1);
        tick(1);
        check("early_walk", int'(walk), 0);
        check("early_dw", int'(dont_walk), 1);
        check("early_cd", int'(countdown), 0);

        // Reset during clearance at countdown 2
        tick(2);
        ped_button = 1'b1;
        tick(1);
        ped_button = 1'b0;
        tick(1);
        set_lamps(1, 0, 0);
        tick(1);
        check("svc2_walk", int'(walk), 1);
        tick(6);
        tick(2);
        check("svc2_cd2", int'(countdown), 2);
        reset = 1'b1;
        tick(1);
        check("rst_walk", int'(walk), 0);
        check("rst_dw", int'(dont_walk), 1);
        check("rst_cd", int'(countdown), 0);
        check("rst_req", int'(req_pending), 0);
        reset = 1'b0;
        set_lamps(0, 0, 1);
        tick(3);
        set_lamps(1, 0, 0);
        tick(1);
        check("no_req_rise", int'(walk), 0);
        tick(3);

        // Press mid-red waits for the next rise
        ped_button = 1'b1;
        tick(1);
        ped_button = 1'b0;
        check("midred_req", int'(req_pending), 1);
        tick(3);
        check("midred_nowalk", int'(walk), 0);
        set_lamps(0, 0, 1);
        tick(2);
        set_lamps(0, 1, 0);
        tick(1);
        set_lamps(1, 0, 0);
        tick(1);
        check("midred_serviced", int'(walk), 1);
        tick(12);

        // Lamp conflict: one-cycle glitch tolerated, two cycles latch fault
        set_lamps(1, 0, 1);
        tick(1);
        set_lamps(1, 0, 0);
        tick(1);
        check("glitch_nofault", int'(fault), 0);
        tick(1);
        set_lamps(1, 0, 1);
        tick(1);
        check("bad1_nofault", int'(fault), 0);
        tick(1);
        check("bad2_fault", int'(fault), 1);
        check("fault_dw", int'(dont_walk), 1);
        set_lamps(1, 0, 0);
        ped_button = 1'b1;
        tick(1);
        ped_button = 1'b0;
        tick(3);
        check("fault_sticky", int'(fault), 1);
        set_lamps(0, 0, 1);
        tick(2);
        set_lamps(1, 0, 0);
        tick(2);
        check("fault_nowalk", int'(walk), 0);
        check("fault_persist", int'(fault), 1);
        reset = 1'b1;
        tick(1);
        check("fault_cleared", int'(fault), 0);
        reset = 1'b0;
        tick(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
